serial_subn: RTL
================

Name: serial_subn

Overview:
- Bit-serial n-bit subtractor: D = X - Y - borrowin.
- One full-subtractor stage is reused for one bit per clock, LSB first.
- Start/busy/done handshake.
- Serves area-constrained datapaths as the subtract counterpart to the parallel n-bit adders; trades n cycles of latency for a single 1-bit cell.

Parameters:
- n, 8, operand/result width in bits; legal range n >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- borrowin  input  1  borrow into bit 0; captured with start.
- X  input  n  minuend; captured with start.
- Y  input  n  subtrahend; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- D  output  n  difference X - Y - borrowin, modulo 2^n.
- borrowout  output  1  borrow out of bit n-1 (unsigned X < Y + borrowin).
- overflow  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state = IDLE; busy = 0, done = 0, D = 0, borrowout = 0, overflow = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start = 1: load xs <= X, ys <= Y, b <= borrowin, cnt <= 0, latch xmsb <= X[n-1] and ymsb <= Y[n-1]; go to RUN.
  - start = 0: remain in IDLE.
- RUN (busy = 1), at each edge:
  - d = xs[0] ^ ys[0] ^ b.
  - bnext = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b).
  - D <= {d, D[n-1:1]} (shift right, new bit enters at MSB).
  - xs, ys shift right by one; b <= bnext; cnt <= cnt + 1.
  - On the edge where cnt == n-1 (n-th bit processed): go to DONE and register borrowout <= bnext.
  - overflow <= (xmsb != ymsb) & (d != xmsb), where d is the bit-(n-1) result.
- DONE: done = 1 for exactly one cycle, busy = 0; unconditionally go to IDLE on the next edge.
- Latency: if start is sampled at edge k, bits are processed at edges k+1..k+n and done is high in the cycle following edge k+n. Throughput is one operation per n+2 cycles.
- start handling:
  - start asserted in RUN or DONE is ignored, not queued.
  - Held-high start re-triggers on the first IDLE edge after DONE.
- Input sampling: X, Y and borrowin are sampled only at the accepting edge; later changes have no effect on the running operation.
- Output validity:
  - D, borrowout and overflow are valid from the done cycle and hold until the next accepted start.
  - During RUN, D holds partial shift contents and is not valid.
  - borrowout and overflow hold their previous values until the DONE transition updates them.
- Counter width: clog2(n+1) bits minimum. For n = 1, RUN lasts exactly one edge.
- Arithmetic: D is always modulo 2^n. borrowin = 1 with X = Y gives D = all ones and borrowout = 1.

Test Plan:
- n=8, X=0x05, Y=0x03, borrowin=0, pulse start -> done exactly 9 cycles after the start edge; D=0x02, borrowout=0, overflow=0; busy high for 8 cycles.
- n=8, X=0x03, Y=0x05, borrowin=0 -> D=0xFE, borrowout=1, overflow=0.
- n=8, X=0x80, Y=0x01 -> D=0x7F, borrowout=0, overflow=1; then X=0x7F, Y=0xFF -> D=0x80, borrowout=1, overflow=1.
- n=8, X=0x00, Y=0x00, borrowin=1 -> D=0xFF, borrowout=1, overflow=0. Change X/Y every cycle during RUN -> result unchanged.
- Start X=0x10, Y=0x01; re-pulse start with X=0xFF, Y=0x00 during RUN -> ignored, D=0x0F. Assert rst at RUN bit 4 -> all outputs 0 immediately, state IDLE, no done pulse.
- n=1 instance: X=0, Y=1, borrowin=0 -> done 2 cycles after start; D=1, borrowout=1. Also hold start high -> back-to-back operations with done every 3 cycles.

Source files
------------

// File: rtl/serial_subn.sv
// Bit-serial n-bit subtractor: D = X - Y - borrowin, one bit per clock, LSB first,
// with a start/busy/done handshake around a single reused full-subtractor cell.
module serial_subn #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         borrowin,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] D,
  output logic         borrowout,
  output logic         overflow
);

  localparam int CW = $clog2(n + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [n-1:0]  xs;
  logic [n-1:0]  ys;
  logic [n-1:0]  dshift;
  logic [CW-1:0] cnt;
  logic          b;
  logic          xmsb;
  logic          ymsb;
  logic          dbit;
  logic          bnext;
  logic          last;

  // New difference bit enters at the MSB; written this way so n = 1 needs no slice.
  always_comb begin
    dbit        = xs[0] ^ ys[0] ^ b;
    bnext       = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    dshift      = D >> 1;
    dshift[n-1] = dbit;
    last        = (cnt == CW'(n - 1));
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      xs        <= '0;
      ys        <= '0;
      D         <= '0;
      cnt       <= '0;
      b         <= 1'b0;
      xmsb      <= 1'b0;
      ymsb      <= 1'b0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xs    <= X;
            ys    <= Y;
            b     <= borrowin;
            cnt   <= '0;
            xmsb  <= X[n-1];
            ymsb  <= Y[n-1];
            state <= RUN;
          end
        end
        RUN: begin
          D   <= dshift;
          xs  <= xs >> 1;
          ys  <= ys >> 1;
          b   <= bnext;
          cnt <= cnt + CW'(1);
          if (last) begin
            borrowout <= bnext;
            overflow  <= (xmsb != ymsb) & (dbit != xmsb);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
